elevator_call_panel: RTL and testbench
======================================

# elevator_call_panel

Front-end stage that turns raw, asynchronous cab (internal) and hall (external) push-buttons plus the emergency stop button into clean, single-cycle request pulses for the elevator controller's `req_int`, `req_ext` and `stop` inputs. It synchronises and debounces every button and keeps a pending-call lamp per button. A lamp clears when the car serves that floor. Only the first press of a not-yet-pending call reaches the controller.

## Interface
- `FLOORS_NUM`, default 5: number of floors, ≥2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a level change, ≥1.
- `clk`  in  1  single system clock; all logic rises on `clk`.
- `rst`  in  1  reset; synchronous and active-high.
- `btn_int`  in  FLOORS_NUM  raw cab buttons, asynchronous, active-high.
- `btn_ext`  in  FLOORS_NUM  raw hall buttons, asynchronous, active-high.
- `btn_stop`  in  1  raw stop button, asynchronous, active-high.
- `curr_floor`  in  $clog2(FLOORS_NUM)  car position from the controller.
- `door`  in  1  controller door-open indication.
- `req_int`  out  FLOORS_NUM  one-cycle cab request pulses to the controller.
- `req_ext`  out  FLOORS_NUM  one-cycle hall request pulses to the controller.
- `stop`  out  1  one-cycle stop pulse to the controller.
- `lamp_int`  out  FLOORS_NUM  pending cab-call lamps.
- `lamp_ext`  out  FLOORS_NUM  pending hall-call lamps.

## Operation
- **Per button channel** (2·FLOORS_NUM+1 channels):
  - Two-flop synchroniser feeds `s2`.
  - Debounce counter feeds the debounced level `stable`.
  - On each edge where `s2 != stable`, the counter increments. On the DEBOUNCE_CYCLES-th consecutive mismatch edge, `stable` takes `s2` and the counter returns to 0.
  - Any edge with `s2 == stable` zeroes the counter. A glitch shorter than DEBOUNCE_CYCLES samples is never accepted.
- **Press event:** a rising edge of `stable`. Falling edges only re-arm the channel.
- **Served floor:** `door==1` and `curr_floor==i`. The served condition clears `lamp_int[i]` and `lamp_ext[i]` on the next edge.
- **Press event on call channel i:**
  - If the lamp is off and floor i is not being served: pulse `req_*[i]` for one cycle and set the lamp.
  - If the lamp is already on: no pulse (duplicate suppression).
  - If floor i is being served: no pulse and no lamp change.
- **Simultaneous events:**
  - Press events on different channels in the same cycle produce pulses in the same cycle, with multiple bits high.
  - A served-floor clear in the same cycle as a press on that floor leaves the lamp off with no pulse.
- **Stop:** a `btn_stop` press event pulses `stop` for one cycle. It has no lamp and never alters call lamps.
- `curr_floor ≥ FLOORS_NUM` matches no floor, so nothing clears.

## Timing
- **Reset values:** all synchronisers, `stable` and counters 0; outputs `req_int`, `req_ext`, `stop`, `lamp_int`, `lamp_ext` all 0. Reset asserted mid-count discards the partial count. A button held across reset release is accepted as a fresh press after full latency.
- **Latency:** call edge 0 the first rising edge at which the raw input is high. Then:
  - `s2` = 1 after edge 1.
  - `stable` = 1 after edge DEBOUNCE_CYCLES+1.
  - Registered pulse and lamp high after edge DEBOUNCE_CYCLES+2, i.e. edge 6 for the default.
- **Pulse width:** exactly one cycle regardless of hold duration. No new pulse until `stable` has fallen and risen again.
- **Release:** also needs DEBOUNCE_CYCLES stable low samples before the channel re-arms.
- **Lamp clear:** lamp low the cycle after the served condition is first sampled.
- **Counter width:** $clog2(DEBOUNCE_CYCLES+1) bits; it never wraps because it resets at DEBOUNCE_CYCLES.

## Structure
- **Shared package `elevator_pkg`:**
  - default `FLOORS_NUM`.
  - `floor_t` = logic [$clog2(FLOORS_NUM)-1:0], shared with the controller's `curr_floor`.
- **Sub-module `button_debouncer`:**
  - One-bit channel: synchroniser, counter, `stable`, and rising-edge output `press`.
  - Parameter `DEBOUNCE_CYCLES`.
  - Instantiated via generate for every call channel and the stop button.
- **Top level:** per-floor lamp and pulse registers, the served-floor compare, and the suppression logic.

## Test plan
- **Clean press:** reset, then `btn_ext=5'b01010` held 10 cycles → `req_ext=5'b01010` for one cycle after edge 6; `lamp_ext=5'b01010`; no further pulses while held.
- **Glitch rejection:** `btn_int[4]` high for 3 cycles only → no `req_int` pulse, `lamp_int` stays 0.
- **Duplicate suppression:** press `btn_int[2]`, release, press again before service → single `req_int[2]` pulse total; second press gives none.
- **Service clear:** `lamp_ext[3]=1`, drive `curr_floor=3`, `door=1` → `lamp_ext[3]` low next cycle. A press of `btn_ext[3]` while still served → no pulse.
- **Stop and mixed simultaneous presses:** `btn_stop`, `btn_int[2]`, `btn_ext[0]` rise on the same edge → `stop`, `req_int=5'b00100` and `req_ext=5'b00001` all pulse in the same cycle.
- **Reset mid-debounce:** `rst` for 1 cycle at count 2 → all outputs 0. A still-held button pulses DEBOUNCE_CYCLES+2 edges after reset release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator call front-end and its controller.
package elevator_pkg;

  localparam int DEF_FLOORS_NUM      = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  typedef logic [$clog2(DEF_FLOORS_NUM)-1:0] floor_t;

  // Counter must hold 0..cycles-1; one extra code keeps the width sane for cycles==1.
  function automatic int deb_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button channel: two-flop synchroniser, consecutive-sample debounce and
// a single-cycle press strobe on each accepted rising edge.
module button_debouncer
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_stable_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_s1       <= btn;
      r_s2       <= r_s1;
      r_stable_q <= r_stable;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_stable & ~r_stable_q;

endmodule

// File: rtl/elevator_call_panel.sv
// Button front-end: debounced cab/hall/stop presses become one-cycle requests,
// with per-floor pending lamps that clear when the car serves the floor.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int FLOORS_NUM      = DEF_FLOORS_NUM,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FLOORS_NUM-1:0]         btn_int,
  input  logic [FLOORS_NUM-1:0]         btn_ext,
  input  logic                          btn_stop,
  input  logic [$clog2(FLOORS_NUM)-1:0] curr_floor,
  input  logic                          door,
  output logic [FLOORS_NUM-1:0]         req_int,
  output logic [FLOORS_NUM-1:0]         req_ext,
  output logic                          stop,
  output logic [FLOORS_NUM-1:0]         lamp_int,
  output logic [FLOORS_NUM-1:0]         lamp_ext
);

  localparam int NCH = 2 * FLOORS_NUM + 1;

  logic [NCH-1:0]        w_btn_raw;
  logic [NCH-1:0]        w_press;
  logic [FLOORS_NUM-1:0] w_press_int;
  logic [FLOORS_NUM-1:0] w_press_ext;
  logic                  w_press_stop;
  logic [FLOORS_NUM-1:0] w_served;
  logic [FLOORS_NUM-1:0] w_new_int;
  logic [FLOORS_NUM-1:0] w_new_ext;
  logic [FLOORS_NUM-1:0] w_lamp_int_nxt;
  logic [FLOORS_NUM-1:0] w_lamp_ext_nxt;

  logic [FLOORS_NUM-1:0] r_req_int;
  logic [FLOORS_NUM-1:0] r_req_ext;
  logic                  r_stop;
  logic [FLOORS_NUM-1:0] r_lamp_int;
  logic [FLOORS_NUM-1:0] r_lamp_ext;

  // Channel order: cab buttons, then hall buttons, then stop in the top bit.
  assign w_btn_raw = {btn_stop, btn_ext, btn_int};

  for (genvar g = 0; g < NCH; g++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (w_btn_raw[g]),
      .press(w_press[g])
    );
  end

  assign w_press_int  = w_press[FLOORS_NUM-1:0];
  assign w_press_ext  = w_press[2*FLOORS_NUM-1:FLOORS_NUM];
  assign w_press_stop = w_press[2*FLOORS_NUM];

  // Out-of-range floor codes compare against no index, so nothing is served.
  always_comb begin
    w_served = '0;
    for (int i = 0; i < FLOORS_NUM; i++) begin
      w_served[i] = door && (int'(curr_floor) == i);
    end
  end

  // A served floor wins over a press in the same cycle: no pulse, lamp off.
  always_comb begin
    w_new_int      = w_press_int & ~r_lamp_int & ~w_served;
    w_new_ext      = w_press_ext & ~r_lamp_ext & ~w_served;
    w_lamp_int_nxt = (r_lamp_int | w_new_int) & ~w_served;
    w_lamp_ext_nxt = (r_lamp_ext | w_new_ext) & ~w_served;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_int  <= '0;
      r_req_ext  <= '0;
      r_stop     <= 1'b0;
      r_lamp_int <= '0;
      r_lamp_ext <= '0;
    end else begin
      r_req_int  <= w_new_int;
      r_req_ext  <= w_new_ext;
      r_stop     <= w_press_stop;
      r_lamp_int <= w_lamp_int_nxt;
      r_lamp_ext <= w_lamp_ext_nxt;
    end
  end

  assign req_int  = r_req_int;
  assign req_ext  = r_req_ext;
  assign stop     = r_stop;
  assign lamp_int = r_lamp_int;
  assign lamp_ext = r_lamp_ext;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Self-checking bench: a window-based behavioural model predicts request pulses
// into a scoreboard queue; a negedge monitor pops and compares them.
module tb_elevator_call_panel;

  localparam int F   = 5;
  localparam int D   = 4;
  localparam int NCH = 2 * F + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [F-1:0] btn_int;
  logic [F-1:0] btn_ext;
  logic         btn_stop;
  logic [2:0]   curr_floor;
  logic         door;
  logic [F-1:0] req_int;
  logic [F-1:0] req_ext;
  logic         stop;
  logic [F-1:0] lamp_int;
  logic [F-1:0] lamp_ext;

  always #5 clk = ~clk;

  elevator_call_panel #(
    .FLOORS_NUM     (F),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_int   (btn_int),
    .btn_ext   (btn_ext),
    .btn_stop  (btn_stop),
    .curr_floor(curr_floor),
    .door      (door),
    .req_int   (req_int),
    .req_ext   (req_ext),
    .stop      (stop),
    .lamp_int  (lamp_int),
    .lamp_ext  (lamp_ext)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           cyc;
    logic [F-1:0] ri;
    logic [F-1:0] re;
    logic         st;
  } pulse_t;

  pulse_t exp_q[$];

  // Reference model: raw samples delayed two edges, a button level is accepted
  // once the last D delayed samples all disagree with the current level.
  bit       m_s1[NCH];
  bit       m_s2[NCH];
  bit       m_stable[NCH];
  bit       m_pend[NCH];
  bit       m_hist[NCH][$];
  bit [F-1:0] m_lamp_int;
  bit [F-1:0] m_lamp_ext;

  int cnt_int[F];
  int cnt_ext[F];
  int cnt_stop = 0;

  always @(posedge clk) begin
    pulse_t p;
    bit     raw;
    bit     s2old;
    bit     all_diff;
    bit     served;
    cyc++;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_stable[c] = 0; m_pend[c] = 0;
        m_hist[c].delete();
      end
      m_lamp_int = '0;
      m_lamp_ext = '0;
    end else begin
      p.cyc = cyc; p.ri = '0; p.re = '0; p.st = 1'b0;
      for (int i = 0; i < F; i++) begin
        served = door && (int'(curr_floor) == i);
        if (served) begin
          m_lamp_int[i] = 0;
          m_lamp_ext[i] = 0;
        end else begin
          if (m_pend[i] && !m_lamp_int[i]) begin m_lamp_int[i] = 1; p.ri[i] = 1'b1; end
          if (m_pend[F+i] && !m_lamp_ext[i]) begin m_lamp_ext[i] = 1; p.re[i] = 1'b1; end
        end
      end
      p.st = m_pend[2*F];
      if (p.ri != '0 || p.re != '0 || p.st) exp_q.push_back(p);
      for (int c = 0; c < NCH; c++) begin
        raw   = (c < F) ? btn_int[c] : (c < 2*F) ? btn_ext[c-F] : btn_stop;
        s2old = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw;
        m_hist[c].push_back(s2old);
        if (m_hist[c].size() > D) void'(m_hist[c].pop_front());
        m_pend[c] = 0;
        if (m_hist[c].size() == D) begin
          all_diff = 1;
          for (int j = 0; j < D; j++) if (m_hist[c][j] == m_stable[c]) all_diff = 0;
          if (all_diff) begin
            m_stable[c] = ~m_stable[c];
            m_pend[c]   = m_stable[c];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    pulse_t e;
    checks++;
    if (lamp_int !== m_lamp_int || lamp_ext !== m_lamp_ext) begin
      errors++;
      $display("FAIL lamps cyc %0d: got int=%b ext=%b expected int=%b ext=%b",
               cyc, lamp_int, lamp_ext, m_lamp_int, m_lamp_ext);
    end
    if (req_int != '0 || req_ext != '0 || stop) begin
      checks++;
      for (int i = 0; i < F; i++) begin
        cnt_int[i] += int'(req_int[i]);
        cnt_ext[i] += int'(req_ext[i]);
      end
      cnt_stop += int'(stop);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc %0d: got int=%b ext=%b stop=%b expected none",
                 cyc, req_int, req_ext, stop);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.ri !== req_int || e.re !== req_ext || e.st !== stop) begin
          errors++;
          $display("FAIL pulse cyc %0d: got int=%b ext=%b stop=%b expected cyc %0d int=%b ext=%b stop=%b",
                   cyc, req_int, req_ext, stop, e.cyc, e.ri, e.re, e.st);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse: got nothing expected cyc %0d int=%b ext=%b stop=%b",
               e.cyc, e.ri, e.re, e.st);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < F; i++) begin cnt_int[i] = 0; cnt_ext[i] = 0; end
    rst = 1; btn_int = '0; btn_ext = '0; btn_stop = 0; curr_floor = '0; door = 0;
    step(3);
    chk("reset_req_int", {27'd0, req_int}, 0);
    chk("reset_lamp_ext", {27'd0, lamp_ext}, 0);
    rst = 0;
    step(2);

    // Clean press with latency and pulse-width checks
    btn_ext = 5'b01010;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("clean_pre_pulse", {27'd0, req_ext}, 0);
    @(posedge clk); @(negedge clk);
    chk("clean_pulse", {27'd0, req_ext}, 32'h0A);
    chk("clean_lamp", {27'd0, lamp_ext}, 32'h0A);
    @(posedge clk); @(negedge clk);
    chk("clean_width", {27'd0, req_ext}, 0);
    step(3);
    btn_ext = '0;
    step(8);

    // Glitch rejection
    btn_int = 5'b10000;
    step(3);
    btn_int = '0;
    step(10);
    chk("glitch_lamp", {27'd0, lamp_int}, 0);
    chk("glitch_cnt", cnt_int[4], 0);

    // Duplicate suppression
    c0 = cnt_int[2];
    btn_int[2] = 1; step(10); btn_int[2] = 0; step(10);
    btn_int[2] = 1; step(10); btn_int[2] = 0; step(10);
    chk("dup_pulses", cnt_int[2] - c0, 1);
    chk("dup_lamp", {31'd0, lamp_int[2]}, 1);

    // Service clear, then press while still served
    btn_ext[3] = 1; step(10); btn_ext[3] = 0; step(8);
    chk("svc_lamp_set", {31'd0, lamp_ext[3]}, 1);
    curr_floor = 3; door = 1;
    @(posedge clk); @(negedge clk);
    chk("svc_lamp_clr", {31'd0, lamp_ext[3]}, 0);
    c0 = cnt_ext[3];
    @(posedge clk); #1;
    btn_ext[3] = 1; step(10); btn_ext[3] = 0; step(8);
    chk("svc_press_pulses", cnt_ext[3] - c0, 0);
    chk("svc_press_lamp", {31'd0, lamp_ext[3]}, 0);
    curr_floor = 2;
    step(2);
    door = 0;
    step(2);

    // Stop with simultaneous cab and hall presses
    btn_stop = 1; btn_int = 5'b00100; btn_ext = 5'b00001;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("sim_stop", {31'd0, stop}, 1);
    chk("sim_req_int", {27'd0, req_int}, 32'h04);
    chk("sim_req_ext", {27'd0, req_ext}, 32'h01);
    @(posedge clk); #1;
    btn_stop = 0; btn_int = '0; btn_ext = '0;
    step(8);

    // Reset mid-debounce, button held across release
    btn_int = 5'b00010;
    step(4);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_lamp_int", {27'd0, lamp_int}, 0);
    chk("rst_lamp_ext", {27'd0, lamp_ext}, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_pulse", {27'd0, req_int}, 0);
    @(posedge clk); @(negedge clk);
    chk("rst_pulse", {27'd0, req_int}, 32'h02);
    @(posedge clk); #1;
    btn_int = '0;
    step(8);

    // Randomised traffic, including out-of-range floors and occasional reset
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < F; i++) begin
        if ($urandom_range(0, 19) == 0) btn_int[i] = ~btn_int[i];
        if ($urandom_range(0, 19) == 0) btn_ext[i] = ~btn_ext[i];
      end
      if ($urandom_range(0, 29) == 0) btn_stop = ~btn_stop;
      if ($urandom_range(0, 9) == 0) door = ~door;
      if ($urandom_range(0, 9) == 0) curr_floor = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 0; btn_int = '0; btn_ext = '0; btn_stop = 0; door = 0;
    step(20);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
